// File: rtl/lru_pkg.sv
// Shared types and constants for the pseudo-LRU / round-robin replacement array.
package lru_pkg;

    typedef enum logic {
        POL_TREE = 1'b0,
        POL_RR   = 1'b1
    } policy_e;

    // Bit n set means WAYS = n is a supported associativity.
    localparam logic [16:0] LEGAL_WAYS = 17'h1_0114;

    function automatic bit ways_is_legal(input int unsigned ways);
        logic [4:0] idx;
        idx = ways[4:0];
        return (ways <= 16) && LEGAL_WAYS[idx];
    endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// Combinational tree pseudo-LRU helpers: victim walk for one set, path update for another.
module plru_tree_logic #(
    parameter  int unsigned WAYS  = 4,
    localparam int unsigned WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  i_tree_rd,
    output logic [WAY_W-1:0] o_victim,
    input  logic [WAYS-2:0]  i_tree_wr,
    input  logic [WAY_W-1:0] i_way,
    output logic [WAYS-2:0]  o_tree_upd
);

    // Padding to WAYS bits lets the node index be exactly WAY_W bits wide.
    logic [WAYS-1:0]  w_rd_pad;
    logic [WAYS-1:0]  w_upd_pad;
    logic [WAY_W-1:0] w_rd_node;
    logic             w_rd_dir;
    logic [WAY_W-1:0] w_up_node;
    logic             w_up_dir;
    logic             w_unused_pad;

    assign w_rd_pad = {1'b0, i_tree_rd};

    always_comb begin
        o_victim  = '0;
        w_rd_node = '0;
        w_rd_dir  = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            w_rd_dir              = w_rd_pad[w_rd_node];
            o_victim[WAY_W-1-l]   = w_rd_dir;
            w_rd_node             = WAY_W'(2 * int'(w_rd_node) + 1 + int'(w_rd_dir));
        end
    end

    // Every node on the accessed way's path is pointed at the opposite subtree.
    always_comb begin
        w_upd_pad = {1'b0, i_tree_wr};
        w_up_node = '0;
        w_up_dir  = 1'b0;
        for (int l = 0; l < WAY_W; l++) begin
            w_up_dir             = i_way[WAY_W-1-l];
            w_upd_pad[w_up_node] = ~w_up_dir;
            w_up_node            = WAY_W'(2 * int'(w_up_node) + 1 + int'(w_up_dir));
        end
    end

    assign o_tree_upd   = w_upd_pad[WAYS-2:0];
    assign w_unused_pad = w_upd_pad[WAYS-1];

endmodule

// File: rtl/plru_policy_array.sv
// Per-set replacement state array with a one-cycle victim lookup and same-edge updates.
module plru_policy_array
    import lru_pkg::*;
#(
    parameter  int unsigned S_INDEX = 4,
    parameter  int unsigned WAYS    = 4,
    parameter  policy_e     POLICY  = POL_TREE,
    localparam int unsigned WAY_W   = $clog2(WAYS)
) (
    input  logic               clk0,
    input  logic               rst0_n,
    input  logic               lkp_valid,
    input  logic [S_INDEX-1:0] lkp_set,
    input  logic [WAYS-1:0]    lkp_inv_mask,
    input  logic               upd_valid,
    input  logic [S_INDEX-1:0] upd_set,
    input  logic [WAY_W-1:0]   upd_way,
    input  logic               upd_fill,
    output logic               vic_valid,
    output logic [WAY_W-1:0]   vic_way
);

    localparam int unsigned NUM_SETS = 2 ** S_INDEX;

    if (!ways_is_legal(WAYS)) begin : g_bad_ways
        $error("plru_policy_array: WAYS must be 2, 4, 8 or 16");
    end

    logic               r_lkp_valid;
    logic [S_INDEX-1:0] r_lkp_set;
    logic [WAYS-1:0]    r_lkp_mask;
    logic [WAY_W-1:0]   w_pol_way;
    logic [WAY_W-1:0]   w_inv_way;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            r_lkp_valid <= 1'b0;
            r_lkp_set   <= '0;
            r_lkp_mask  <= '0;
        end else begin
            r_lkp_valid <= lkp_valid;
            r_lkp_set   <= lkp_set;
            r_lkp_mask  <= lkp_inv_mask;
        end
    end

    // Descending scan so the lowest-indexed invalid way wins.
    always_comb begin
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_lkp_mask[w]) begin
                w_inv_way = WAY_W'(w);
            end
        end
    end

    assign vic_valid = r_lkp_valid;
    assign vic_way   = !r_lkp_valid   ? '0        :
                       (|r_lkp_mask)  ? w_inv_way : w_pol_way;

    if (POLICY == POL_TREE) begin : g_tree
        logic [WAYS-2:0] r_tree [NUM_SETS];
        logic [WAYS-2:0] w_tree_upd;
        logic            w_unused_fill;

        assign w_unused_fill = upd_fill;

        plru_tree_logic #(
            .WAYS(WAYS)
        ) u_tree (
            .i_tree_rd  (r_tree[r_lkp_set]),
            .o_victim   (w_pol_way),
            .i_tree_wr  (r_tree[upd_set]),
            .i_way      (upd_way),
            .o_tree_upd (w_tree_upd)
        );

        always_ff @(posedge clk0 or negedge rst0_n) begin
            if (!rst0_n) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    r_tree[s] <= '0;
                end
            end else if (upd_valid) begin
                r_tree[upd_set] <= w_tree_upd;
            end
        end
    end else begin : g_rr
        logic [WAY_W-1:0] r_cnt [NUM_SETS];
        logic [WAY_W-1:0] w_unused_way;

        assign w_unused_way = upd_way;
        assign w_pol_way    = r_cnt[r_lkp_set];

        // WAYS is a power of two, so natural overflow gives the modulo wrap.
        always_ff @(posedge clk0 or negedge rst0_n) begin
            if (!rst0_n) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    r_cnt[s] <= '0;
                end
            end else if (upd_valid && upd_fill) begin
                r_cnt[upd_set] <= r_cnt[upd_set] + WAY_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_plru_policy_array.sv
// Randomised and directed bench for plru_policy_array, tree and round-robin instances side by side.
module tb_plru_policy_array;
    import lru_pkg::*;

    localparam int unsigned S_INDEX  = 4;
    localparam int unsigned WAYS     = 4;
    localparam int unsigned NUM_SETS = 16;

    logic       clk0 = 1'b0;
    logic       rst0_n;
    logic       lkp_valid;
    logic [3:0] lkp_set;
    logic [3:0] lkp_inv_mask;
    logic       upd_valid;
    logic [3:0] upd_set;
    logic [1:0] upd_way;
    logic       upd_fill;
    logic       vic_valid_t, vic_valid_r;
    logic [1:0] vic_way_t, vic_way_r;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-way last-access time (tree), per-set fill count (rr).
    int stamp  [NUM_SETS][WAYS];
    int rr_cnt [NUM_SETS];
    int now_t;

    logic       exp_valid;
    logic [1:0] exp_tree;
    logic [1:0] exp_rr;

    always #5 clk0 = ~clk0;

    plru_policy_array #(
        .S_INDEX (S_INDEX),
        .WAYS    (WAYS),
        .POLICY  (POL_TREE)
    ) u_dut_tree (
        .clk0         (clk0),
        .rst0_n       (rst0_n),
        .lkp_valid    (lkp_valid),
        .lkp_set      (lkp_set),
        .lkp_inv_mask (lkp_inv_mask),
        .upd_valid    (upd_valid),
        .upd_set      (upd_set),
        .upd_way      (upd_way),
        .upd_fill     (upd_fill),
        .vic_valid    (vic_valid_t),
        .vic_way      (vic_way_t)
    );

    plru_policy_array #(
        .S_INDEX (S_INDEX),
        .WAYS    (WAYS),
        .POLICY  (POL_RR)
    ) u_dut_rr (
        .clk0         (clk0),
        .rst0_n       (rst0_n),
        .lkp_valid    (lkp_valid),
        .lkp_set      (lkp_set),
        .lkp_inv_mask (lkp_inv_mask),
        .upd_valid    (upd_valid),
        .upd_set      (upd_set),
        .upd_way      (upd_way),
        .upd_fill     (upd_fill),
        .vic_valid    (vic_valid_r),
        .vic_way      (vic_way_r)
    );

    task automatic model_reset();
        now_t = 0;
        for (int s = 0; s < NUM_SETS; s++) begin
            rr_cnt[s] = 0;
            for (int w = 0; w < WAYS; w++) stamp[s][w] = 0;
        end
    endtask

    // Tree PLRU as "at each split, walk away from the half holding the most recent access".
    function automatic int model_victim(input int s, input logic [3:0] m, input bit rr);
        int lo, hi, mid, ml, mr, res;
        bit found;
        found = 1'b0;
        res   = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (m[w] && !found) begin
                res   = w;
                found = 1'b1;
            end
        end
        if (!found && rr) begin
            res = rr_cnt[s];
        end else if (!found) begin
            lo = 0;
            hi = WAYS;
            while (hi - lo > 1) begin
                mid = (lo + hi) / 2;
                ml  = 0;
                mr  = 0;
                for (int w = lo; w < mid; w++) if (stamp[s][w] > ml) ml = stamp[s][w];
                for (int w = mid; w < hi; w++) if (stamp[s][w] > mr) mr = stamp[s][w];
                if (ml > mr) lo = mid;
                else         hi = mid;
            end
            res = lo;
        end
        return res;
    endfunction

    // Drives one cycle of stimulus; on return outputs of that lookup are settled (edge + 1).
    task automatic drive_cycle(input logic lv, input logic [3:0] ls, input logic [3:0] lm,
                               input logic uv, input logic [3:0] us, input logic [1:0] uw,
                               input logic uf);
        lkp_valid    = lv;
        lkp_set      = ls;
        lkp_inv_mask = lm;
        upd_valid    = uv;
        upd_set      = us;
        upd_way      = uw;
        upd_fill     = uf;
        if (uv) begin
            now_t++;
            stamp[us][uw] = now_t;
            if (uf) rr_cnt[us] = (rr_cnt[us] + 1) % WAYS;
        end
        exp_valid = lv;
        exp_tree  = lv ? 2'(model_victim(int'(ls), lm, 1'b0)) : 2'd0;
        exp_rr    = lv ? 2'(model_victim(int'(ls), lm, 1'b1)) : 2'd0;
        @(posedge clk0);
        #1;
        lkp_valid = 1'b0;
        upd_valid = 1'b0;
        upd_fill  = 1'b0;
    endtask

    task automatic test_reset();
        rst0_n       = 1'b0;
        lkp_valid    = 1'b0;
        lkp_set      = '0;
        lkp_inv_mask = '0;
        upd_valid    = 1'b0;
        upd_set      = '0;
        upd_way      = '0;
        upd_fill     = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (vic_valid_t !== 1'b0 || vic_way_t !== 2'd0 ||
            vic_valid_r !== 1'b0 || vic_way_r !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_state: tree %b/%0d rr %b/%0d, expected 0/0", vic_valid_t,
                     vic_way_t, vic_valid_r, vic_way_r);
        end
        repeat (2) @(posedge clk0);
        #3 rst0_n = 1'b1;
        @(posedge clk0);
        #1;
        n_checks++;
        if (vic_valid_t !== 1'b0 || vic_valid_r !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_valid: tree %b rr %b, expected 0", vic_valid_t, vic_valid_r);
        end
        drive_cycle(1'b1, 4'd3, 4'b0000, 1'b0, 4'd0, 2'd0, 1'b0);
        n_checks++;
        if (vic_valid_t !== 1'b1 || vic_way_t !== 2'd0 ||
            vic_valid_r !== 1'b1 || vic_way_r !== 2'd0) begin
            n_errors++;
            $display("FAIL first_victim: tree %b/%0d rr %b/%0d, expected 1/0", vic_valid_t,
                     vic_way_t, vic_valid_r, vic_way_r);
        end
    endtask

    task automatic test_tree_touch();
        logic [1:0] ways [3];
        logic [1:0] want [3];
        ways = '{2'd0, 2'd2, 2'd1};
        want = '{2'd2, 2'd1, 2'd3};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 4'd0, 4'b0000, 1'b1, 4'd5, ways[i], 1'b0);
            drive_cycle(1'b1, 4'd5, 4'b0000, 1'b0, 4'd0, 2'd0, 1'b0);
            n_checks++;
            if (vic_valid_t !== 1'b1 || vic_way_t !== want[i] ||
                vic_valid_r !== 1'b1 || vic_way_r !== 2'd0) begin
                n_errors++;
                $display("FAIL tree_touch[%0d]: tree %b/%0d rr %b/%0d, expected 1/%0d and 1/0",
                         i, vic_valid_t, vic_way_t, vic_valid_r, vic_way_r, want[i]);
            end
        end
    endtask

    task automatic test_rr_fill();
        logic [1:0] want [4];
        want = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 4'd0, 4'b0000, 1'b1, 4'd15, 2'(i), 1'b1);
            drive_cycle(1'b1, 4'd15, 4'b0000, 1'b0, 4'd0, 2'd0, 1'b0);
            n_checks++;
            if (vic_valid_r !== 1'b1 || vic_way_r !== want[i] ||
                vic_valid_t !== 1'b1 || vic_way_t !== exp_tree) begin
                n_errors++;
                $display("FAIL rr_fill[%0d]: rr %b/%0d tree %b/%0d, expected 1/%0d and 1/%0d",
                         i, vic_valid_r, vic_way_r, vic_valid_t, vic_way_t, want[i], exp_tree);
            end
        end
    endtask

    task automatic test_mask();
        drive_cycle(1'b0, 4'd0, 4'b0000, 1'b1, 4'd7, 2'd3, 1'b1);
        drive_cycle(1'b1, 4'd7, 4'b0110, 1'b0, 4'd0, 2'd0, 1'b0);
        n_checks++;
        if (vic_valid_t !== 1'b1 || vic_way_t !== 2'd1 ||
            vic_valid_r !== 1'b1 || vic_way_r !== 2'd1) begin
            n_errors++;
            $display("FAIL inv_mask: tree %b/%0d rr %b/%0d, expected 1/1", vic_valid_t,
                     vic_way_t, vic_valid_r, vic_way_r);
        end
    endtask

    task automatic test_same_cycle();
        drive_cycle(1'b1, 4'd2, 4'b0000, 1'b1, 4'd2, 2'd0, 1'b0);
        n_checks++;
        if (vic_valid_t !== 1'b1 || vic_way_t !== 2'd2 ||
            vic_valid_r !== 1'b1 || vic_way_r !== 2'd0) begin
            n_errors++;
            $display("FAIL same_cycle: tree %b/%0d rr %b/%0d, expected 1/2 and 1/0",
                     vic_valid_t, vic_way_t, vic_valid_r, vic_way_r);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] lm;
        for (int i = 0; i < 400; i++) begin
            lm = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            drive_cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), lm,
                        1'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
            n_checks++;
            if (vic_valid_t !== exp_valid || vic_way_t !== exp_tree ||
                vic_valid_r !== exp_valid || vic_way_r !== exp_rr) begin
                n_errors++;
                $display("FAIL random[%0d]: tree %b/%0d rr %b/%0d, expected %b/%0d and %b/%0d",
                         i, vic_valid_t, vic_way_t, vic_valid_r, vic_way_r,
                         exp_valid, exp_tree, exp_valid, exp_rr);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, 4'd9, 4'b0000, 1'b1, 4'd9, 2'd1, 1'b1);
        n_checks++;
        if (vic_valid_t !== 1'b1 || vic_valid_r !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset_valid: tree %b rr %b, expected 1", vic_valid_t, vic_valid_r);
        end
        #2 rst0_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (vic_valid_t !== 1'b0 || vic_way_t !== 2'd0 ||
            vic_valid_r !== 1'b0 || vic_way_r !== 2'd0) begin
            n_errors++;
            $display("FAIL async_reset: tree %b/%0d rr %b/%0d, expected 0/0", vic_valid_t,
                     vic_way_t, vic_valid_r, vic_way_r);
        end
        @(posedge clk0);
        #3 rst0_n = 1'b1;
        @(posedge clk0);
        #1;
        drive_cycle(1'b1, 4'd9, 4'b0000, 1'b0, 4'd0, 2'd0, 1'b0);
        n_checks++;
        if (vic_valid_t !== 1'b1 || vic_way_t !== 2'd0 ||
            vic_valid_r !== 1'b1 || vic_way_r !== 2'd0) begin
            n_errors++;
            $display("FAIL post_reset_victim: tree %b/%0d rr %b/%0d, expected 1/0",
                     vic_valid_t, vic_way_t, vic_valid_r, vic_way_r);
        end
    endtask

    initial begin
        test_reset();
        test_tree_touch();
        test_rr_fill();
        test_mask();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
